ps2_digit_entry: RTL and testbench
==================================

# ps2_digit_entry

Parametrised PS/2 scan-code digit-entry engine. Consumes the byte stream from the PS/2 receiver one byte at a time and decodes make, break (F0) and extended (E0) sequences. Decoded hex digits go into a DIGITS-deep nibble shift buffer with backspace, clear and enter editing. Successor to the fixed 32-bit keycode splitter: the buffer is generic and stateful, and it supports typematic suppression and a latched entry value that feeds the display and arithmetic logic.

## Interface
Parameters:
- DIGITS, 4, number of nibble slots in the entry buffer (1..8)
- HEX_EN, 1, 1 = keys A–F accepted as digits 10–15; 0 = only 0–9 accepted
- REPEAT_SUPPRESS, 1, 1 = repeated make of the held key ignored until its break; 0 = every make accepted

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- byte_valid  in  1  single-cycle strobe; byte_in valid this cycle
- byte_in  in  8  scan-code byte from PS/2 receiver
- digits  out  4*DIGITS  buffer; [3:0] = newest digit (num1), upper nibbles older
- digit_count  out  4  number of valid digits, 0..DIGITS
- key_release  out  1  one-cycle pulse on completed break sequence (kr successor)
- last_code  out  8  final code byte of the last completed make or break
- entry_valid  out  1  one-cycle pulse on Enter
- entry_value  out  4*DIGITS  copy of digits captured at Enter

## Operation
- Decoder FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). State advances only on cycles with byte_valid=1.
- IDLE transitions: F0 -> BRK; E0 -> EXT; any other byte is a make code -> processed, stays IDLE.
- EXT transitions: F0 -> EXT_BRK; any other byte is an extended make -> IDLE.
- BRK and EXT_BRK: the next byte is the break code -> key_release pulse, last_code = byte, FSM -> IDLE.
- Make-code map, non-extended: 45,16,1E,26,25,2E,36,3D,3E,46 -> digits 0–9; 1C,32,21,23,24,2B -> A–F when HEX_EN=1.
  - Digit make: shift left one nibble, new digit enters [3:0], oldest nibble is discarded when full. digit_count increments, saturating at DIGITS.
  - 66 (backspace): shift right one nibble, top nibble zero-filled. digit_count decrements. No change when the count is 0.
  - 76 (Esc): digits = 0, digit_count = 0.
  - 5A (Enter), or extended 5A (keypad Enter): entry_valid pulse, entry_value = digits. The buffer is then cleared: digits = 0, digit_count = 0.
- Extended makes other than 5A are ignored except for last_code and the held-key register. All other unmapped codes likewise update only last_code and the held-key register.
- Typematic suppression (REPEAT_SUPPRESS=1):
  - held register = {ext, code} of the last accepted make, with a held_valid flag.
  - A make equal to the held key while held_valid=1 is ignored entirely.
  - A break matching the held key clears held_valid. Breaks of other keys leave it set.
- last_code updates on every completed make or break, including ignored and unmapped codes.

## Timing
- All outputs registered. Each effect is visible the cycle after the byte_valid cycle: latency 1.
- key_release and entry_valid are high for exactly one cycle and never asserted on prefix bytes (F0, E0).
- Back-to-back byte_valid on consecutive cycles is supported. Each byte is fully processed with no stall and no backpressure.
- Prefix-only cycles (F0, E0 accepted) change only the FSM state. Outputs hold.
- F0 received while in BRK or EXT_BRK is treated as the break code: pulse key_release with last_code = F0, return to IDLE.
- Reset values: FSM = IDLE, digits = 0, digit_count = 0, entry_value = 0, last_code = 0, key_release = 0, entry_valid = 0, held_valid = 0.
- A reset asserted mid-sequence (e.g., after F0) discards the prefix. The next byte is decoded from IDLE.
- Reset has priority over a simultaneous byte_valid.

## Test plan
- Reset, then bytes 16,1E,26,25 (DIGITS=4) -> digits=16'h1234, digit_count=4; no key_release pulses.
- From the 1234 state, byte 2E -> digits=16'h2345, digit_count=4 (oldest digit dropped, count saturated).
- Bytes 16,F0,16 -> digits=16'h0001. Exactly one key_release pulse, one cycle after the second 16, with last_code=16.
- REPEAT_SUPPRESS=1: bytes 1E,1E,1E,F0,1E,1E -> digits=16'h0022, count=2. REPEAT_SUPPRESS=0, same stream -> digits=16'h2222.
- Bytes 26,36,66,E0,5A -> after 66: digits=16'h0003, count=1. After 5A: entry_valid pulse, entry_value=16'h0003, digits=0, count=0.
- HEX_EN=0, bytes 1C,45 -> digits=16'h0000, count=1, last_code=45. Then F0 followed by reset, then 45 -> digits=16'h0000, count=1, no key_release pulse.

Source files
------------

// File: rtl/ps2_digit_entry.sv
// PS/2 scan-code digit-entry engine: decodes make/break/extended byte sequences
// into a nibble shift buffer with backspace, clear and enter, plus typematic suppression.
module ps2_digit_entry #(
  parameter int DIGITS          = 4,
  parameter int HEX_EN          = 1,
  parameter int REPEAT_SUPPRESS = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_in_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [3:0]            digit_count_o,
  output logic                  key_release_o,
  output logic [7:0]            last_code_o,
  output logic                  entry_valid_o,
  output logic [4*DIGITS-1:0]   entry_value_o
);

  localparam int W        = 4 * DIGITS;
  localparam bit HEX_OK   = (HEX_EN != 0);
  localparam bit SUPPRESS = (REPEAT_SUPPRESS != 0);

  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_ESC   = 8'h76;
  localparam logic [7:0] CODE_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  // Returns {valid, value} for a non-extended digit make code.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    logic [4:0] dec;
    case (code)
      8'h45:   dec = {1'b1, 4'h0};
      8'h16:   dec = {1'b1, 4'h1};
      8'h1E:   dec = {1'b1, 4'h2};
      8'h26:   dec = {1'b1, 4'h3};
      8'h25:   dec = {1'b1, 4'h4};
      8'h2E:   dec = {1'b1, 4'h5};
      8'h36:   dec = {1'b1, 4'h6};
      8'h3D:   dec = {1'b1, 4'h7};
      8'h3E:   dec = {1'b1, 4'h8};
      8'h46:   dec = {1'b1, 4'h9};
      8'h1C:   dec = {HEX_OK, 4'hA};
      8'h32:   dec = {HEX_OK, 4'hB};
      8'h21:   dec = {HEX_OK, 4'hC};
      8'h23:   dec = {HEX_OK, 4'hD};
      8'h24:   dec = {HEX_OK, 4'hE};
      8'h2B:   dec = {HEX_OK, 4'hF};
      default: dec = 5'h00;
    endcase
    return dec;
  endfunction

  state_e         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic [3:0]     count_q, count_d;
  logic           key_release_q, key_release_d;
  logic [7:0]     last_code_q, last_code_d;
  logic           entry_valid_q, entry_valid_d;
  logic [W-1:0]   entry_value_q, entry_value_d;
  logic [8:0]     held_q, held_d;
  logic           held_valid_q, held_valid_d;

  logic           is_make_s;
  logic           is_break_s;
  logic           ext_s;
  logic [8:0]     key_s;
  logic [4:0]     dec_s;
  logic           suppress_s;

  // Decoder FSM: classify the incoming byte as prefix, make or break.
  always_comb begin
    state_d    = state_q;
    is_make_s  = 1'b0;
    is_break_s = 1'b0;
    ext_s      = 1'b0;
    if (byte_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (byte_in_i == CODE_BRK) begin
            state_d = S_BRK;
          end else if (byte_in_i == CODE_EXT) begin
            state_d = S_EXT;
          end else begin
            is_make_s = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_in_i == CODE_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            is_make_s = 1'b1;
            ext_s     = 1'b1;
            state_d   = S_IDLE;
          end
        end
        // Any byte after F0, including a second F0, completes the break.
        S_BRK: begin
          is_break_s = 1'b1;
          state_d    = S_IDLE;
        end
        S_EXT_BRK: begin
          is_break_s = 1'b1;
          ext_s      = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign key_s      = {ext_s, byte_in_i};
  assign dec_s      = decode_digit(byte_in_i);
  assign suppress_s = SUPPRESS && held_valid_q && (held_q == key_s);

  // Buffer editing, held-key tracking and output pulse generation.
  always_comb begin
    digits_d      = digits_q;
    count_d       = count_q;
    key_release_d = 1'b0;
    last_code_d   = last_code_q;
    entry_valid_d = 1'b0;
    entry_value_d = entry_value_q;
    held_d        = held_q;
    held_valid_d  = held_valid_q;
    if (is_break_s) begin
      key_release_d = 1'b1;
      last_code_d   = byte_in_i;
      if (held_q == key_s) begin
        held_valid_d = 1'b0;
      end
    end else if (is_make_s) begin
      last_code_d = byte_in_i;
      if (!suppress_s) begin
        held_d       = key_s;
        held_valid_d = 1'b1;
        if (!ext_s && dec_s[4]) begin
          digits_d = (digits_q << 4) | W'(dec_s[3:0]);
          if (count_q < 4'(DIGITS)) begin
            count_d = count_q + 4'd1;
          end
        end else if (!ext_s && byte_in_i == CODE_BKSP) begin
          if (count_q != 4'd0) begin
            digits_d = digits_q >> 4;
            count_d  = count_q - 4'd1;
          end
        end else if (!ext_s && byte_in_i == CODE_ESC) begin
          digits_d = '0;
          count_d  = 4'd0;
        end else if (byte_in_i == CODE_ENTER) begin
          entry_valid_d = 1'b1;
          entry_value_d = digits_q;
          digits_d      = '0;
          count_d       = 4'd0;
        end
      end
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      digits_q      <= '0;
      count_q       <= 4'd0;
      key_release_q <= 1'b0;
      last_code_q   <= 8'h00;
      entry_valid_q <= 1'b0;
      entry_value_q <= '0;
      held_q        <= 9'h000;
      held_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digits_q      <= digits_d;
      count_q       <= count_d;
      key_release_q <= key_release_d;
      last_code_q   <= last_code_d;
      entry_valid_q <= entry_valid_d;
      entry_value_q <= entry_value_d;
      held_q        <= held_d;
      held_valid_q  <= held_valid_d;
    end
  end

  assign digits_o      = digits_q;
  assign digit_count_o = count_q;
  assign key_release_o = key_release_q;
  assign last_code_o   = last_code_q;
  assign entry_valid_o = entry_valid_q;
  assign entry_value_o = entry_value_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed scoreboard bench for ps2_digit_entry: default, no-suppress and
// decimal-only instances share one clock, reset and byte bus.
module tb_ps2_digit_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bv_a = 1'b0, bv_b = 1'b0, bv_c = 1'b0;
  logic [7:0]  byte_in = 8'h00;

  logic [15:0] dig_a, dig_b, dig_c, evv_a, evv_b, evv_c;
  logic [3:0]  cnt_a, cnt_b, cnt_c;
  logic        kr_a, kr_b, kr_c, ev_a, ev_b, ev_c;
  logic [7:0]  lc_a, lc_b, lc_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    string       tag;
    logic [15:0] dig;
    logic [3:0]  cnt;
    logic        kr;
    logic [7:0]  lc;
    logic        ev;
    logic [15:0] evv;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ps2_digit_entry #(.DIGITS(4), .HEX_EN(1), .REPEAT_SUPPRESS(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .byte_valid_i(bv_a), .byte_in_i(byte_in),
    .digits_o(dig_a), .digit_count_o(cnt_a), .key_release_o(kr_a),
    .last_code_o(lc_a), .entry_valid_o(ev_a), .entry_value_o(evv_a));

  ps2_digit_entry #(.DIGITS(4), .HEX_EN(1), .REPEAT_SUPPRESS(0)) dut_b (
    .clk_i(clk), .reset_i(reset), .byte_valid_i(bv_b), .byte_in_i(byte_in),
    .digits_o(dig_b), .digit_count_o(cnt_b), .key_release_o(kr_b),
    .last_code_o(lc_b), .entry_valid_o(ev_b), .entry_value_o(evv_b));

  ps2_digit_entry #(.DIGITS(4), .HEX_EN(0), .REPEAT_SUPPRESS(1)) dut_c (
    .clk_i(clk), .reset_i(reset), .byte_valid_i(bv_c), .byte_in_i(byte_in),
    .digits_o(dig_c), .digit_count_o(cnt_c), .key_release_o(kr_c),
    .last_code_o(lc_c), .entry_valid_o(ev_c), .entry_value_o(evv_c));

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [15:0] dig, input logic [3:0] cnt,
                      input logic kr, input logic [7:0] lc, input logic ev, input logic [15:0] evv);
    exp_t e;
    e.sel = sel; e.tag = tag; e.dig = dig; e.cnt = cnt;
    e.kr = kr; e.lc = lc; e.ev = ev; e.evv = evv;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [15:0] dig, evv;
    logic [3:0]  cnt;
    logic        kr, ev;
    logic [7:0]  lc;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin dig = dig_a; cnt = cnt_a; kr = kr_a; lc = lc_a; ev = ev_a; evv = evv_a; end
        1:       begin dig = dig_b; cnt = cnt_b; kr = kr_b; lc = lc_b; ev = ev_b; evv = evv_b; end
        default: begin dig = dig_c; cnt = cnt_c; kr = kr_c; lc = lc_c; ev = ev_c; evv = evv_c; end
      endcase
      cmp({e.tag, ".digits"},      dig,          e.dig);
      cmp({e.tag, ".digit_count"}, 16'(cnt),     16'(e.cnt));
      cmp({e.tag, ".key_release"}, 16'(kr),      16'(e.kr));
      cmp({e.tag, ".last_code"},   16'(lc),      16'(e.lc));
      cmp({e.tag, ".entry_valid"}, 16'(ev),      16'(e.ev));
      cmp({e.tag, ".entry_value"}, evv,          e.evv);
    end
  endtask

  // One byte (or idle cycle when v=0) to instance sel; expectation checked one cycle later.
  task automatic step(input int sel, input logic v, input logic [7:0] b, input string tag,
                      input logic [15:0] dig, input logic [3:0] cnt, input logic kr,
                      input logic [7:0] lc, input logic ev, input logic [15:0] evv);
    @(negedge clk);
    byte_in = b;
    bv_a = v && (sel == 0);
    bv_b = v && (sel == 1);
    bv_c = v && (sel == 2);
    push(sel, tag, dig, cnt, kr, lc, ev, evv);
    @(posedge clk);
    #1;
    bv_a = 1'b0; bv_b = 1'b0; bv_c = 1'b0;
    pop_check();
  endtask

  // One reset cycle, optionally with a colliding byte on instance c; all outputs must clear.
  task automatic rst_step(input logic bvc, input logic [7:0] b, input string tag);
    @(negedge clk);
    reset = 1'b1;
    bv_c = bvc;
    byte_in = b;
    for (int s = 0; s < 3; s++) push(s, tag, 16'h0000, 4'd0, 1'b0, 8'h00, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bv_c = 1'b0;
    for (int s = 0; s < 3; s++) pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    rst_step(1'b0, 8'h00, "reset");

    // Instance a: digit entry, saturation, clear, break, typematic suppression
    step(0, 1, 8'h16, "a_d1",    16'h0001, 4'd1, 0, 8'h16, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_d2",    16'h0012, 4'd2, 0, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'h26, "a_d3",    16'h0123, 4'd3, 0, 8'h26, 0, 16'h0000);
    step(0, 1, 8'h25, "a_d4",    16'h1234, 4'd4, 0, 8'h25, 0, 16'h0000);
    step(0, 1, 8'h2E, "a_sat",   16'h2345, 4'd4, 0, 8'h2E, 0, 16'h0000);
    step(0, 1, 8'h76, "a_esc",   16'h0000, 4'd0, 0, 8'h76, 0, 16'h0000);
    step(0, 1, 8'h16, "a_mk1",   16'h0001, 4'd1, 0, 8'h16, 0, 16'h0000);
    step(0, 1, 8'hF0, "a_f0",    16'h0001, 4'd1, 0, 8'h16, 0, 16'h0000);
    step(0, 1, 8'h16, "a_brk1",  16'h0001, 4'd1, 1, 8'h16, 0, 16'h0000);
    step(0, 0, 8'h00, "a_krlow", 16'h0001, 4'd1, 0, 8'h16, 0, 16'h0000);
    step(0, 1, 8'h76, "a_esc2",  16'h0000, 4'd0, 0, 8'h76, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_rp1",   16'h0002, 4'd1, 0, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_rp2",   16'h0002, 4'd1, 0, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_rp3",   16'h0002, 4'd1, 0, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'hF0, "a_rpf0",  16'h0002, 4'd1, 0, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_rpbrk", 16'h0002, 4'd1, 1, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_rp4",   16'h0022, 4'd2, 0, 8'h1E, 0, 16'h0000);
    step(0, 1, 8'h1E, "a_rp5",   16'h0022, 4'd2, 0, 8'h1E, 0, 16'h0000);
    // Backspace and keypad Enter
    step(0, 1, 8'h76, "a_esc3",  16'h0000, 4'd0, 0, 8'h76, 0, 16'h0000);
    step(0, 1, 8'h26, "a_e3",    16'h0003, 4'd1, 0, 8'h26, 0, 16'h0000);
    step(0, 1, 8'h36, "a_e6",    16'h0036, 4'd2, 0, 8'h36, 0, 16'h0000);
    step(0, 1, 8'h66, "a_bksp",  16'h0003, 4'd1, 0, 8'h66, 0, 16'h0000);
    step(0, 1, 8'hE0, "a_e0",    16'h0003, 4'd1, 0, 8'h66, 0, 16'h0000);
    step(0, 1, 8'h5A, "a_kpent", 16'h0000, 4'd0, 0, 8'h5A, 1, 16'h0003);
    step(0, 0, 8'h00, "a_evlow", 16'h0000, 4'd0, 0, 8'h5A, 0, 16'h0003);
    step(0, 1, 8'h66, "a_bksp0", 16'h0000, 4'd0, 0, 8'h66, 0, 16'h0003);
    // Hex digits, unmapped and extended makes, main Enter
    step(0, 1, 8'h1C, "a_hexA",  16'h000A, 4'd1, 0, 8'h1C, 0, 16'h0003);
    step(0, 1, 8'h32, "a_hexB",  16'h00AB, 4'd2, 0, 8'h32, 0, 16'h0003);
    step(0, 1, 8'hA1, "a_unmap", 16'h00AB, 4'd2, 0, 8'hA1, 0, 16'h0003);
    step(0, 1, 8'hE0, "a_e0b",   16'h00AB, 4'd2, 0, 8'hA1, 0, 16'h0003);
    step(0, 1, 8'h75, "a_extmk", 16'h00AB, 4'd2, 0, 8'h75, 0, 16'h0003);
    step(0, 1, 8'h5A, "a_enter", 16'h0000, 4'd0, 0, 8'h5A, 1, 16'h00AB);
    // F0 F0 completes a break of F0; E0 F0 xx is an extended break
    step(0, 1, 8'hF0, "a_ff1",   16'h0000, 4'd0, 0, 8'h5A, 0, 16'h00AB);
    step(0, 1, 8'hF0, "a_ff2",   16'h0000, 4'd0, 1, 8'hF0, 0, 16'h00AB);
    step(0, 1, 8'hE0, "a_xb1",   16'h0000, 4'd0, 0, 8'hF0, 0, 16'h00AB);
    step(0, 1, 8'hF0, "a_xb2",   16'h0000, 4'd0, 0, 8'hF0, 0, 16'h00AB);
    step(0, 1, 8'h75, "a_xb3",   16'h0000, 4'd0, 1, 8'h75, 0, 16'h00AB);
    // Enter is still held (no break seen), so its repeat is suppressed
    step(0, 1, 8'h5A, "a_entrp", 16'h0000, 4'd0, 0, 8'h5A, 0, 16'h00AB);

    // Instance b: no typematic suppression
    step(1, 1, 8'h1E, "b_1",     16'h0002, 4'd1, 0, 8'h1E, 0, 16'h0000);
    step(1, 1, 8'h1E, "b_2",     16'h0022, 4'd2, 0, 8'h1E, 0, 16'h0000);
    step(1, 1, 8'h1E, "b_3",     16'h0222, 4'd3, 0, 8'h1E, 0, 16'h0000);
    step(1, 1, 8'hF0, "b_f0",    16'h0222, 4'd3, 0, 8'h1E, 0, 16'h0000);
    step(1, 1, 8'h1E, "b_brk",   16'h0222, 4'd3, 1, 8'h1E, 0, 16'h0000);
    step(1, 1, 8'h1E, "b_4",     16'h2222, 4'd4, 0, 8'h1E, 0, 16'h0000);

    // Instance c: decimal only, reset discards a pending break prefix
    step(2, 1, 8'h1C, "c_hexoff", 16'h0000, 4'd0, 0, 8'h1C, 0, 16'h0000);
    step(2, 1, 8'h45, "c_zero",   16'h0000, 4'd1, 0, 8'h45, 0, 16'h0000);
    step(2, 1, 8'hF0, "c_f0",     16'h0000, 4'd1, 0, 8'h45, 0, 16'h0000);
    rst_step(1'b1, 8'h45, "c_rstpri");
    step(2, 1, 8'h45, "c_after",  16'h0000, 4'd1, 0, 8'h45, 0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
